// File: rtl/move_search_ctrl_if.sv
// Bundle of game-FSM, profile-RAM and scorer signals for move_search_ctrl.
`default_nettype none

interface move_search_ctrl_if;
   logic       start;
   logic [7:0] cur_x;
   logic [7:0] cur_y;
   logic [7:0] cur_profile;
   logic [7:0] width;
   logic [7:0] length;
   logic       color;
   logic       my_move;
   logic       mem_rd;
   logic [7:0] mem_x;
   logic [7:0] mem_y;
   logic [7:0] mem_data;
   logic [7:0] eval_old_x;
   logic [7:0] eval_old_y;
   logic [7:0] eval_new_x;
   logic [7:0] eval_new_y;
   logic [7:0] eval_profile;
   logic       eval_perm;
   logic       eval_color;
   logic       eval_my_move;
   logic [7:0] score;
   logic       busy;
   logic       done;
   logic [2:0] best_dir;
   logic [7:0] best_x;
   logic [7:0] best_y;
   logic [7:0] best_score;
   logic       no_move;

   // Environment side: game FSM, profile RAM and scorer.
   modport master (
      output start, cur_x, cur_y, cur_profile, width, length, color, my_move,
             mem_data, score,
      input  mem_rd, mem_x, mem_y, eval_old_x, eval_old_y, eval_new_x, eval_new_y,
             eval_profile, eval_perm, eval_color, eval_my_move,
             busy, done, best_dir, best_x, best_y, best_score, no_move
   );

   modport slave (
      input  start, cur_x, cur_y, cur_profile, width, length, color, my_move,
             mem_data, score,
      output mem_rd, mem_x, mem_y, eval_old_x, eval_old_y, eval_new_x, eval_new_y,
             eval_profile, eval_perm, eval_color, eval_my_move,
             busy, done, best_dir, best_x, best_y, best_score, no_move
   );
endinterface

`default_nettype wire

// File: rtl/move_search_ctrl.sv
// Sweeps the eight neighbours of the ball, reads each legal candidate's profile, scores it
// and keeps the best. Define SCORE_REG_EN to register the score and compare in EVAL2.
`default_nettype none

module move_search_ctrl (
   input  wire logic         clk,
   input  wire logic         rst,
   move_search_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WAIT  = 3'd2,
      EVAL  = 3'd3,
      EVAL2 = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] dir;
   logic [7:0] pos_x, pos_y, prof, lim_x, lim_y, cand_prof;
   logic       color, my_move, found;
   logic [2:0] best_dir;
   logic [7:0] best_x, best_y, best_score;
   logic       no_move;

   logic [8:0] step_x, step_y, cand_x, cand_y;
   logic       legal, better;
   logic [7:0] cmp_score;

   // Steps are 9-bit two's complement so underflow shows up in bit 8.
   always_comb begin
      step_x = 9'd0;
      step_y = 9'd0;
      case (dir)
         3'd0: step_y = 9'h1FF;
         3'd1: begin step_x = 9'd1;   step_y = 9'h1FF; end
         3'd2: step_x = 9'd1;
         3'd3: begin step_x = 9'd1;   step_y = 9'd1;   end
         3'd4: step_y = 9'd1;
         3'd5: begin step_x = 9'h1FF; step_y = 9'd1;   end
         3'd6: step_x = 9'h1FF;
         default: begin step_x = 9'h1FF; step_y = 9'h1FF; end
      endcase
      cand_x = {1'b0, pos_x} + step_x;
      cand_y = {1'b0, pos_y} + step_y;
      legal  = !cand_x[8] && !cand_y[8] && (cand_x[7:0] <= lim_x) &&
               (cand_y[7:0] <= lim_y) && !prof[dir];
   end

`ifdef SCORE_REG_EN
   logic [7:0] score_q;
   always_ff @(posedge clk) begin
      if (rst) score_q <= 8'd0;
      else     score_q <= bus.score;
   end
   assign cmp_score = score_q;
`else
   assign cmp_score = bus.score;
`endif

   assign better = !found || (my_move ? (cmp_score > best_score) : (cmp_score < best_score));

   always_comb begin
      state_nxt   = state;
      bus.mem_rd    = 1'b0;
      bus.eval_perm = 1'b0;
      bus.done      = 1'b0;
      bus.busy      = (state != IDLE);
      case (state)
         IDLE: if (bus.start) state_nxt = ADDR;
         ADDR: begin
            if (legal) begin
               bus.mem_rd = 1'b1;
               state_nxt  = WAIT;
            end else if (dir == 3'd7) begin
               state_nxt = DONE;
            end
         end
         WAIT: state_nxt = EVAL;
         EVAL: begin
            bus.eval_perm = 1'b1;
`ifdef SCORE_REG_EN
            state_nxt = EVAL2;
`else
            state_nxt = (dir == 3'd7) ? DONE : ADDR;
`endif
         end
         EVAL2: begin
            bus.eval_perm = 1'b1;
            state_nxt     = (dir == 3'd7) ? DONE : ADDR;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dir        <= 3'd0;
         pos_x      <= 8'd0;
         pos_y      <= 8'd0;
         prof       <= 8'd0;
         lim_x      <= 8'd0;
         lim_y      <= 8'd0;
         color      <= 1'b0;
         my_move    <= 1'b0;
         found      <= 1'b0;
         cand_prof  <= 8'd0;
         best_dir   <= 3'd0;
         best_x     <= 8'd0;
         best_y     <= 8'd0;
         best_score <= 8'd0;
         no_move    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (bus.start) begin
               pos_x      <= bus.cur_x;
               pos_y      <= bus.cur_y;
               prof       <= bus.cur_profile;
               lim_x      <= bus.width;
               lim_y      <= bus.length;
               color      <= bus.color;
               my_move    <= bus.my_move;
               dir        <= 3'd0;
               found      <= 1'b0;
               best_dir   <= 3'd0;
               best_x     <= 8'd0;
               best_y     <= 8'd0;
               best_score <= 8'd0;
               no_move    <= 1'b0;
            end
            ADDR: if (!legal) begin
               if (dir == 3'd7) no_move <= ~found;
               else             dir     <= dir + 3'd1;
            end
            WAIT: cand_prof <= bus.mem_data;
`ifdef SCORE_REG_EN
            EVAL2: begin
`else
            EVAL: begin
`endif
               if (better) begin
                  best_dir   <= dir;
                  best_x     <= cand_x[7:0];
                  best_y     <= cand_y[7:0];
                  best_score <= cmp_score;
               end
               found <= 1'b1;
               if (dir == 3'd7) no_move <= 1'b0;
               else             dir     <= dir + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_x        = cand_x[7:0];
   assign bus.mem_y        = cand_y[7:0];
   assign bus.eval_old_x   = pos_x;
   assign bus.eval_old_y   = pos_y;
   assign bus.eval_new_x   = cand_x[7:0];
   assign bus.eval_new_y   = cand_y[7:0];
   assign bus.eval_profile = cand_prof;
   assign bus.eval_color   = color;
   assign bus.eval_my_move = my_move;
   assign bus.best_dir     = best_dir;
   assign bus.best_x       = best_x;
   assign bus.best_y       = best_y;
   assign bus.best_score   = best_score;
   assign bus.no_move      = no_move;

endmodule

`default_nettype wire

// File: doc/move_search_ctrl.md
# move_search_ctrl

Sequencer that picks the next move for the paper-soccer engine by sweeping the eight neighbours of the ball position. For each in-bounds candidate whose edge is still free, it:
- reads the candidate point's line profile from the field-profile RAM;
- presents the move to the combinational move scorer and samples the returned score;
- keeps the best candidate so far.

It sits between the game FSM, which issues `start` and consumes `done`/`best_*`, and the profile RAM plus scorer, which it time-shares across the eight directions.

## Interface
Parameters:
- none; all datapaths fixed at 8 bits (coordinates, profile, score).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `cur_x`, `cur_y` in 8: ball position; latched at start.
- `cur_profile` in 8: lines already drawn at the ball point; bit d set means direction d is used. Latched at start.
- `width`, `length` in 8: field extent; legal x is 0..width, legal y is 0..length. Latched at start.
- `color` in 1: player colour; latched and forwarded to the scorer.
- `my_move` in 1: 1 selects the maximum score, 0 selects the minimum (opponent model). Latched.
- `mem_rd` out 1: profile RAM read strobe.
- `mem_x`, `mem_y` out 8: RAM address.
- `mem_data` in 8: RAM profile, valid exactly 1 cycle after `mem_rd`.
- `eval_old_x`, `eval_old_y`, `eval_new_x`, `eval_new_y`, `eval_profile` out 8: scorer operands.
- `eval_perm` out 1: scorer permit input; 1 during EVAL, 0 otherwise.
- `eval_color`, `eval_my_move` out 1: scorer operands.
- `score` in 8: scorer result, combinational from the `eval_*` outputs.
- `busy` out 1: high from the cycle after start is accepted until DONE, inclusive.
- `done` out 1: one-cycle pulse.
- `best_dir` out 3: direction of the selected move.
- `best_x`, `best_y` out 8: coordinates of the selected move.
- `best_score` out 8: score of the selected move.
- `no_move` out 1: no legal direction was found.

## Operation
- Direction encoding, with x increasing east and y increasing south: 0=N(0,-1), 1=NE(+1,-1), 2=E(+1,0), 3=SE(+1,+1), 4=S(0,+1), 5=SW(-1,+1), 6=W(-1,0), 7=NW(-1,-1).
- Candidate arithmetic:
  - computed in 9 bits, as the zero-extended coordinate plus the sign-extended step;
  - the candidate is out of bounds if bit 8 is set (underflow) or it exceeds `width`/`length`.
- A candidate is legal when it is in bounds and `cur_profile[d]==0`.
- States and transitions:
  - IDLE: on start, latch the inputs, set d=0, clear the `found` flag, and go to ADDR.
  - ADDR: if the candidate is illegal, skip it; go to DONE if d==7, else increment d and stay in ADDR. If it is legal, pulse `mem_rd` with the candidate address and go to WAIT.
  - WAIT: the RAM latency cycle.
  - EVAL:
    - drive the `eval_*` outputs, with `eval_profile`=`mem_data` registered in WAIT, and `eval_perm`=1;
    - sample `score`;
    - update the best registers if `found`==0, or if the score is strictly greater (when `my_move`=1) or strictly less (when `my_move`=0) than the current best;
    - set `found`;
    - go to DONE if d==7, else increment d and go to ADDR.
  - DONE: assert `done` for one cycle, set `no_move`=~`found`, and go to IDLE.
- Ties go to the lowest direction index, because updates use strict comparison.
- With `no_move`=1, the best outputs hold their reset/cleared values: dir 0, coordinates 0, score 0.
- The best outputs are cleared at start and are stable from DONE until the next accepted start.
- `start` is ignored while busy. `cur_*` and the other latched inputs may change freely after the start cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd`=0, `eval_perm`=0, `best_dir`=0, `best_x`=0, `best_y`=0, `best_score`=0, `no_move`=0; state is IDLE.
- Cycle cost: 1 cycle per illegal direction and 3 per legal direction. Let start be sampled at cycle 0.
  - With L legal directions, DONE/`done` occurs at cycle 9+2L.
  - All legal: `done` at cycle 25. None legal: `done` at cycle 9.
- `rst` during a search returns to IDLE on the next edge with reset values on all outputs. No `done` is produced for the aborted search.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `SCORE_REG_EN` defined:
  - a register stage is inserted on `score`;
  - an extra state, EVAL2, follows EVAL and performs the comparison;
  - the `eval_*` outputs hold through EVAL2;
  - legal directions cost 4 cycles, so `done` occurs at cycle 9+3L.
- Undefined: the comparison happens in EVAL as specified above.

## Test plan
- Centre, all legal: width=8, length=10, cur=(4,5), `cur_profile`=0x00, scorer model returns 10·d, `my_move`=1 -> 8 `mem_rd` pulses, `done` at cycle 25, `best_dir`=7, `best_x`=3, `best_y`=4, `best_score`=70.
- Corner: cur=(0,0), `cur_profile`=0x00 -> `mem_rd` only for d=2,3,4 at addresses (1,0),(1,1),(0,1), `done` at cycle 15.
- Blocked: `cur_profile`=0xFF -> no `mem_rd`, `done` at cycle 9, `no_move`=1, `best_score`=0.
- Tie and min-select: all scores 12 -> `best_dir`=0. Separately, `my_move`=0 with scores {30,20,20,40,50,60,70,80} -> `best_dir`=1, `best_score`=20.
- Reset and ignored start: `rst` at cycle 10 of a full search -> `busy`=0 at cycle 11, no `done`; a new start afterwards completes normally. A start issued at cycle 5 of a search is ignored.
- `SCORE_REG_EN` build: repeat the centre case -> `done` at cycle 33, same result.
